// File: rtl/max_dec_blk_if.sv
// Sample-path bus for max_dec_blk: raw samples and window controls in, window extreme out.
// PEAK_INDEX_EN adds the peak_idx signal.
interface max_dec_blk_if #(
    parameter int unsigned DW = 12,
    parameter int unsigned GW = 6,
    parameter int unsigned OW = 8,
    parameter int unsigned CW = 8
);
    logic [DW-1:0] data_in;
    logic          din_valid;
    logic [GW-1:0] mul_c;
    logic [CW-1:0] win_len;
    logic          mode;
    logic [OW-1:0] data_out;
    logic          data_valid;
    logic          sat_flag;
`ifdef PEAK_INDEX_EN
    logic [CW-1:0] peak_idx;
`endif

    modport master (
        output data_in, din_valid, mul_c, win_len, mode,
`ifdef PEAK_INDEX_EN
        input  peak_idx,
`endif
        input  data_out, data_valid, sat_flag
    );

    modport slave (
        input  data_in, din_valid, mul_c, win_len, mode,
`ifdef PEAK_INDEX_EN
        output peak_idx,
`endif
        output data_out, data_valid, sat_flag
    );
endinterface

// File: rtl/max_dec_blk.sv
// Gain-scale, saturate and window max/min decimator (3-stage pipeline).
// Define PEAK_INDEX_EN to add the peak_idx output.
module max_dec_blk #(
    parameter int unsigned DW    = 12,
    parameter int unsigned GW    = 6,
    parameter int unsigned OW    = 8,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned CW    = 8
) (
    input logic          sysclk,
    input logic          rst_n,
    input logic          sync_n,
    max_dec_blk_if.slave bus
);
    localparam int unsigned PW = DW + GW;

    logic [PW-1:0] prod_q, prod_d;
    logic          v1_q, v2_q;
    logic [OW-1:0] s_q, s_d;
    logic          s_sat_q, s_sat_d;
    logic [CW-1:0] cnt_q, wl_q;
    logic          md_q;
    logic [OW-1:0] acc_q, acc_d;
    logic          sat_acc_q, sat_d;
    logic [OW-1:0] data_out_q;
    logic          data_valid_q, sat_flag_q;
    logic          first, eff_md, take, last_smp;
    logic [CW-1:0] eff_wl;
`ifdef PEAK_INDEX_EN
    logic [CW-1:0] idx_q, idx_d, peak_idx_q;
`endif

    assign prod_d = PW'(bus.data_in) * PW'(bus.mul_c);

    always_comb begin
        s_sat_d = (prod_q >> (SHIFT + OW)) != '0;
        s_d     = s_sat_d ? '1 : OW'(prod_q >> SHIFT);
    end

    // Window length and mode are taken live for the first sample, then held until window end.
    always_comb begin
        first    = (cnt_q == '0);
        eff_wl   = first ? bus.win_len : wl_q;
        eff_md   = first ? bus.mode : md_q;
        take     = first || (eff_md ? (s_q < acc_q) : (s_q > acc_q));
        acc_d    = take ? s_q : acc_q;
        sat_d    = s_sat_q | (sat_acc_q & ~first);
        last_smp = (cnt_q == eff_wl);
`ifdef PEAK_INDEX_EN
        idx_d    = take ? cnt_q : idx_q;
`endif
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q       <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            s_q          <= '0;
            s_sat_q      <= 1'b0;
            cnt_q        <= '0;
            wl_q         <= '0;
            md_q         <= 1'b0;
            acc_q        <= '0;
            sat_acc_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sat_flag_q   <= 1'b0;
`ifdef PEAK_INDEX_EN
            idx_q        <= '0;
            peak_idx_q   <= '0;
`endif
        end else if (!sync_n) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            sat_acc_q    <= 1'b0;
            data_valid_q <= 1'b0;
`ifdef PEAK_INDEX_EN
            idx_q        <= '0;
            peak_idx_q   <= '0;
`endif
        end else begin
            prod_q       <= prod_d;
            v1_q         <= bus.din_valid;
            s_q          <= s_d;
            s_sat_q      <= s_sat_d;
            v2_q         <= v1_q;
            data_valid_q <= 1'b0;
            if (v2_q) begin
                acc_q     <= acc_d;
                sat_acc_q <= sat_d;
`ifdef PEAK_INDEX_EN
                idx_q     <= idx_d;
`endif
                if (first) begin
                    wl_q <= bus.win_len;
                    md_q <= bus.mode;
                end
                if (last_smp) begin
                    cnt_q        <= '0;
                    data_out_q   <= acc_d;
                    data_valid_q <= 1'b1;
                    sat_flag_q   <= sat_d;
`ifdef PEAK_INDEX_EN
                    peak_idx_q   <= idx_d;
`endif
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.sat_flag   = sat_flag_q;
`ifdef PEAK_INDEX_EN
    assign bus.peak_idx   = peak_idx_q;
`endif
endmodule
